// File: rtl/mult_pkg.sv
// Shared types and constants for the round-robin shift-add multiplier.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_core.sv
// Shift-add multiplier datapath: operand capture on load, one partial-product
// step per step pulse, with a step counter flagging the final step.
module mult_core
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last_step,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [2*WIDTH-1:0] addend;

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else if (load) begin
         mcand_reg  <= {{WIDTH{1'b0}}, a};
         mplier_reg <= b;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else if (step) begin
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         acc_reg    <= acc_reg + addend;
         count_reg  <= count_reg + 1'b1;
      end
   end

   // product includes the current step so the final sum is available on the last RUN edge
   assign addend    = mplier_reg[0] ? mcand_reg : '0;
   assign product   = acc_reg + addend;
   assign last_step = (count_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one shift-add multiplier;
// FSM IDLE -> RUN (WIDTH cycles) -> DONE (one cycle, valid/ack) -> IDLE.
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   A0,
   input  logic [WIDTH-1:0]   B0,
   input  logic [WIDTH-1:0]   A1,
   input  logic [WIDTH-1:0]   B1,
   output logic               ack0,
   output logic               ack1,
   output logic [2*WIDTH-1:0] result,
   output logic               valid,
   output logic               owner,
   output logic               busy
);

   state_t             state_reg, state_next;
   logic               owner_reg, owner_next;
   logic               last_owner_reg, last_owner_next;
   logic [2*WIDTH-1:0] result_reg, result_next;

   logic               grant;
   logic               load;
   logic               step;
   logic               last_step;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] product;

   // both requesting: hand over to whoever did not go last
   assign grant = (req0 && req1) ? ~last_owner_reg : req1;
   assign op_a  = grant ? A1 : A0;
   assign op_b  = grant ? B1 : B0;

   mult_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .a         (op_a),
      .b         (op_b),
      .last_step (last_step),
      .product   (product)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;
         result_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         result_reg     <= result_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      result_next     = result_reg;
      load            = 1'b0;
      step            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               load            = 1'b1;
               owner_next      = grant;
               last_owner_next = grant;
               state_next      = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last_step) begin
               result_next = product;
               state_next  = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign valid  = (state_reg == DONE);
   assign ack0   = valid && !owner_reg;
   assign ack1   = valid && owner_reg;
   assign busy   = (state_reg != IDLE);
   assign owner  = owner_reg;
   assign result = result_reg;

endmodule
